// File: rtl/dallanma_ongorucu.sv
// Branch predictor: 32-entry direct-mapped BTB with 2-bit saturating counters and one-cycle lookup.
// Optional gshare counter indexing when DALLANMA_GSHARE_EN is defined.
module dallanma_ongorucu #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] ps_i,
    input  logic              ps_gecerli_i,
    output logic              ongoru_gecerli_o,
    output logic              ongoru_atladi_o,
    output logic [DATA_W-1:0] ongoru_ps_o,
    input  logic [DATA_W-1:0] g2_ps_i,
    input  logic [DATA_W-1:0] g2_hedef_ps_i,
    input  logic              g2_guncelle_i,
    input  logic              g2_atladi_i,
    input  logic              g2_hatali_tahmin_i
);

    localparam int IDX_W   = 5;
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = DATA_W - (IDX_W + 1);
    localparam int CTR_W   = 2;

    localparam logic [CTR_W-1:0] CTR_MAX   = 2'b11;
    localparam logic [CTR_W-1:0] CTR_MIN   = 2'b00;
    localparam logic [CTR_W-1:0] CTR_RESET = 2'b01;
    localparam logic [CTR_W-1:0] CTR_ALLOC = 2'b10;

    function automatic logic [CTR_W-1:0] sat_ctr(input logic [CTR_W-1:0] ctr,
                                                  input logic           yukari);
        if (yukari)
            return (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'b01;
        else
            return (ctr == CTR_MIN) ? CTR_MIN : ctr - 2'b01;
    endfunction

    logic [ENTRIES-1:0] gecerli_tbl;
    logic [TAG_W-1:0]   etiket_tbl [ENTRIES];
    logic [DATA_W-1:0]  hedef_tbl  [ENTRIES];
    logic [CTR_W-1:0]   sayac_tbl  [ENTRIES];

    logic [IDX_W-1:0] ara_idx_p0;
    logic [IDX_W-1:0] ara_sidx_p0;
    logic [IDX_W-1:0] gun_idx;
    logic [IDX_W-1:0] gun_sidx;
    logic             ara_isabet_p0;
    logic             gun_isabet;
    logic             vld_p0;
    logic             atladi_p0;

    logic              vld_p1;
    logic              atladi_p1;
    logic [DATA_W-1:0] hedef_p1;

    logic unused_bits;
    assign unused_bits = ^{ps_i[0], g2_ps_i[0]};

    assign ara_idx_p0 = ps_i[IDX_W:1];
    assign gun_idx    = g2_ps_i[IDX_W:1];

`ifdef DALLANMA_GSHARE_EN
    // History advances only at commit, so lookup and update see the same non-speculative value.
    logic [IDX_W-1:0] gecmis;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            gecmis <= '0;
        else if (g2_guncelle_i)
            gecmis <= {gecmis[IDX_W-2:0], g2_atladi_i};
    end

    assign ara_sidx_p0 = ara_idx_p0 ^ gecmis;
    assign gun_sidx    = gun_idx ^ gecmis;
`else
    assign ara_sidx_p0 = ara_idx_p0;
    assign gun_sidx    = gun_idx;
`endif

    assign ara_isabet_p0 = gecerli_tbl[ara_idx_p0] &&
                           (etiket_tbl[ara_idx_p0] == ps_i[DATA_W-1:IDX_W+1]);
    assign gun_isabet    = gecerli_tbl[gun_idx] &&
                           (etiket_tbl[gun_idx] == g2_ps_i[DATA_W-1:IDX_W+1]);

    assign vld_p0    = ps_gecerli_i & ~g2_hatali_tahmin_i;
    assign atladi_p0 = vld_p0 & ara_isabet_p0 & sayac_tbl[ara_sidx_p0][1];

    // Table update: nonblocking writes keep same-cycle lookups on the old contents.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gecerli_tbl <= '0;
            for (int i = 0; i < ENTRIES; i++)
                sayac_tbl[i] <= CTR_RESET;
        end else if (g2_guncelle_i) begin
            if (g2_atladi_i && !gun_isabet) begin
                gecerli_tbl[gun_idx] <= 1'b1;
                sayac_tbl[gun_sidx]  <= CTR_ALLOC;
            end else begin
                sayac_tbl[gun_sidx]  <= sat_ctr(sayac_tbl[gun_sidx], g2_atladi_i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && g2_guncelle_i && g2_atladi_i) begin
            etiket_tbl[gun_idx] <= g2_ps_i[DATA_W-1:IDX_W+1];
            hedef_tbl[gun_idx]  <= g2_hedef_ps_i;
        end
    end

    // p0 -> p1: registered prediction
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1    <= 1'b0;
            atladi_p1 <= 1'b0;
        end else begin
            vld_p1    <= vld_p0;
            atladi_p1 <= atladi_p0;
        end
    end

    always_ff @(posedge clk_i) begin
        hedef_p1 <= hedef_tbl[ara_idx_p0];
    end

    assign ongoru_gecerli_o = vld_p1;
    assign ongoru_atladi_o  = atladi_p1;
    assign ongoru_ps_o      = atladi_p1 ? hedef_p1 : '0;

endmodule

// File: tb/tb_dallanma_ongorucu.sv
// Directed bench for dallanma_ongorucu (default build, gshare indexing disabled).
module tb_dallanma_ongorucu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] ps_i;
    logic        ps_gecerli_i;
    logic        ongoru_gecerli_o;
    logic        ongoru_atladi_o;
    logic [31:0] ongoru_ps_o;
    logic [31:0] g2_ps_i;
    logic [31:0] g2_hedef_ps_i;
    logic        g2_guncelle_i;
    logic        g2_atladi_i;
    logic        g2_hatali_tahmin_i;

    int gecen  = 0;
    int toplam = 0;

    dallanma_ongorucu dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .ps_i               (ps_i),
        .ps_gecerli_i       (ps_gecerli_i),
        .ongoru_gecerli_o   (ongoru_gecerli_o),
        .ongoru_atladi_o    (ongoru_atladi_o),
        .ongoru_ps_o        (ongoru_ps_o),
        .g2_ps_i            (g2_ps_i),
        .g2_hedef_ps_i      (g2_hedef_ps_i),
        .g2_guncelle_i      (g2_guncelle_i),
        .g2_atladi_i        (g2_atladi_i),
        .g2_hatali_tahmin_i (g2_hatali_tahmin_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic bos();
        rst_i              = 1'b0;
        ps_gecerli_i       = 1'b0;
        g2_guncelle_i      = 1'b0;
        g2_atladi_i        = 1'b0;
        g2_hatali_tahmin_i = 1'b0;
    endtask

    task automatic ara(input logic [31:0] pc);
        ps_i         = pc;
        ps_gecerli_i = 1'b1;
    endtask

    task automatic guncelle(input logic [31:0] pc, input logic [31:0] hedef, input logic at);
        g2_ps_i       = pc;
        g2_hedef_ps_i = hedef;
        g2_atladi_i   = at;
        g2_guncelle_i = 1'b1;
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
        bos();
    endtask

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                           input logic [31:0] beklenen);
        toplam++;
        assert (gozlenen === beklenen) gecen++;
        else $error("FAIL %s observed=%h expected=%h", etiket, gozlenen, beklenen);
    endtask

    task automatic tahmin(input string etiket, input logic g, input logic a,
                          input logic [31:0] p);
        kontrol({etiket, ".gecerli"}, {31'd0, ongoru_gecerli_o}, {31'd0, g});
        kontrol({etiket, ".atladi"},  {31'd0, ongoru_atladi_o},  {31'd0, a});
        kontrol({etiket, ".ps"},      ongoru_ps_o,               p);
    endtask

    initial begin
        ps_i = '0; g2_ps_i = '0; g2_hedef_ps_i = '0;
        bos();

        // reset with a simultaneous taken update and lookup
        rst_i = 1'b1; ara(32'h0040_0000); guncelle(32'h0040_0000, 32'h0040_0020, 1'b1);
        @(posedge clk_i); #1;
        rst_i = 1'b1; ara(32'h0040_0000); guncelle(32'h0040_0000, 32'h0040_0020, 1'b1);
        cyc();
        tahmin("reset", 1'b0, 1'b0, 32'h0);

        // cold lookup misses
        ara(32'h0040_0000); cyc();
        tahmin("cold_lookup", 1'b1, 1'b0, 32'h0);

        // allocate on taken, then hit; no lookup issued during update
        guncelle(32'h0040_0000, 32'h0040_0020, 1'b1); cyc();
        kontrol("idle.gecerli", {31'd0, ongoru_gecerli_o}, 32'd0);
        ara(32'h0040_0000); cyc();
`ifdef DALLANMA_GSHARE_EN
        tahmin("alloc_hit", 1'b1, 1'b0, 32'h0);
`else
        tahmin("alloc_hit", 1'b1, 1'b1, 32'h0040_0020);
`endif

        // saturate down, then climb back (counter 2->1->0->0)
        guncelle(32'h0040_0000, 32'h0040_0020, 1'b0); cyc();
        guncelle(32'h0040_0000, 32'h0040_0020, 1'b0); cyc();
        guncelle(32'h0040_0000, 32'h0040_0020, 1'b0); cyc();
        ara(32'h0040_0000); cyc();
        tahmin("ctr0", 1'b1, 1'b0, 32'h0);
        guncelle(32'h0040_0000, 32'h0040_0030, 1'b1); cyc();
        ara(32'h0040_0000); cyc();
        tahmin("ctr1", 1'b1, 1'b0, 32'h0);
        guncelle(32'h0040_0000, 32'h0040_0040, 1'b1); cyc();
        ara(32'h0040_0000); cyc();
        tahmin("ctr2_newtarget", 1'b1, 1'b1, 32'h0040_0040);

        // alias on index 0 replaces the prior occupant
        guncelle(32'h0080_0000, 32'h0080_0100, 1'b1); cyc();
        ara(32'h0040_0000); cyc();
        tahmin("alias_old_miss", 1'b1, 1'b0, 32'h0);
        ara(32'h0080_0000); cyc();
        tahmin("alias_new_hit", 1'b1, 1'b1, 32'h0080_0100);

        // same-cycle lookup sees pre-update contents
        ara(32'h0040_0004); guncelle(32'h0040_0004, 32'h0040_0444, 1'b1); cyc();
        tahmin("same_cycle", 1'b1, 1'b0, 32'h0);
        ara(32'h0040_0004); cyc();
        tahmin("next_cycle", 1'b1, 1'b1, 32'h0040_0444);

        // back-to-back lookups to different entries
        ara(32'h0080_0000); cyc();
        tahmin("b2b_a", 1'b1, 1'b1, 32'h0080_0100);
        ara(32'h0040_0040); cyc();
        tahmin("b2b_b_miss", 1'b1, 1'b0, 32'h0);

        // not-taken miss leaves BTB alone (counter 1->0); a taken miss then allocates at 2
        guncelle(32'h00C0_0010, 32'h00C0_0200, 1'b0); cyc();
        ara(32'h00C0_0010); cyc();
        tahmin("nt_miss", 1'b1, 1'b0, 32'h0);
        guncelle(32'h00C0_0010, 32'h00C0_0200, 1'b1); cyc();
        ara(32'h00C0_0010); cyc();
        tahmin("alloc_after_nt", 1'b1, 1'b1, 32'h00C0_0200);

        // misprediction squashes the lookup
        ara(32'h0040_0004); g2_hatali_tahmin_i = 1'b1; cyc();
        tahmin("mispredict", 1'b0, 1'b0, 32'h0);

        // reset while updating: everything invalid afterwards
        rst_i = 1'b1; ara(32'h0040_0004); guncelle(32'h0040_0004, 32'h0040_0888, 1'b1); cyc();
        tahmin("reset2", 1'b0, 1'b0, 32'h0);
        ara(32'h0040_0004); cyc();
        tahmin("post_reset_a", 1'b1, 1'b0, 32'h0);
        ara(32'h0080_0000); cyc();
        tahmin("post_reset_b", 1'b1, 1'b0, 32'h0);
        ara(32'h00C0_0010); cyc();
        tahmin("post_reset_c", 1'b1, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", gecen, toplam);
        $finish;
    end

endmodule

// File: doc/dallanma_ongorucu.md
DALLANMA_ONGORUCU -- requirements
Module: dallanma_ongorucu

Interface
REQ-001 SHALL have these ports (name  direction  width  meaning):
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 ps_i  in  32  fetch-stage PC to predict.
REQ-005 ps_gecerli_i  in  1  ps_i valid this cycle.
REQ-006 ongoru_gecerli_o  out  1  prediction outputs valid (registered).
REQ-007 ongoru_atladi_o  out  1  predicted taken.
REQ-008 ongoru_ps_o  out  32  predicted target; 0 when not predicted taken.
REQ-009 g2_ps_i  in  32  resolved branch PC, from the branch unit.
REQ-010 g2_hedef_ps_i  in  32  resolved branch target.
REQ-011 g2_guncelle_i  in  1  update strobe, one cycle per resolved branch/jump.
REQ-012 g2_atladi_i  in  1  resolved outcome, 1 = taken.
REQ-013 g2_hatali_tahmin_i  in  1  misprediction; fetch is being redirected.

Function
REQ-014 SHALL hold 32 entries, each: valid bit, 26-bit tag (PC[31:6]), 32-bit target, 2-bit saturating counter.
REQ-015 BTB index (valid/tag/target) SHALL be PC[5:1] (RVC-aligned); counter index per REQ-029/030.
REQ-016 Lookup latency SHALL be 1 cycle: ps_gecerli_i at cycle N -> outputs valid at N+1.
REQ-017 Hit SHALL be valid[idx] and tag[idx] == ps_i[31:6].
REQ-018 ongoru_atladi_o SHALL be hit and counter[1]; ongoru_ps_o = target[idx] if taken, else 0.
REQ-019 ongoru_gecerli_o SHALL be 0 at N+1 if ps_gecerli_i was 0 or g2_hatali_tahmin_i was 1 at N; atladi/ps then 0.
REQ-020 On g2_guncelle_i, counter SHALL increment if g2_atladi_i, else decrement; saturate at 3 and 0.
REQ-021 Update hit, taken: target SHALL be overwritten with g2_hedef_ps_i.
REQ-022 Update miss, taken: entry SHALL be allocated (valid=1, tag, target, counter=2), replacing any prior occupant.
REQ-023 Update miss, not taken: BTB SHALL be unchanged; counter still decremented per REQ-020.
REQ-024 Lookup and update in the same cycle on the same index: lookup SHALL see pre-update contents (no bypass).
REQ-025 Update takes effect for lookups issued in the following cycle and later.

Reset
REQ-026 On rst_i, in the same edge: all valid bits 0, all counters 2'b01 (weakly not taken), history register 0, all outputs 0.
REQ-027 rst_i SHALL override a simultaneous g2_guncelle_i or lookup; no table write occurs.
REQ-028 Target/tag arrays need not be reset (gated by valid).

Configuration
REQ-029 With DALLANMA_GSHARE_EN defined: 5-bit global history register; counter index = PC[5:1] XOR history, for both lookup and update; on each g2_guncelle_i the history shifts left, LSB = g2_atladi_i (commit-time, non-speculative; update uses history before the shift).
REQ-030 Without DALLANMA_GSHARE_EN: no history register; counter index = PC[5:1]; all other behaviour identical.

Verification
REQ-031 After reset, lookup ps_i=0x00400000 -> next cycle gecerli=1, atladi=0, ps=0.
REQ-032 Update ps=0x00400000, hedef=0x00400020, taken; then lookup 0x00400000 -> atladi=1, ps=0x00400020 (GSHARE off; with GSHARE on, history=1 yields a different counter index, so expect atladi=0).
REQ-033 GSHARE off: 3 not-taken updates on allocated 0x00400000 -> counter 0 (saturated); 1 taken -> counter 1, lookup atladi=0; 2nd taken -> counter 2, atladi=1.
REQ-034 Alias: allocate 0x00400000, then taken update 0x00800000 (same index) -> lookup 0x00400000 misses, atladi=0; lookup 0x00800000 hits.
REQ-035 Same-cycle lookup and first taken update on 0x00400004 -> that lookup atladi=0; lookup next cycle atladi=1.
REQ-036 ps_gecerli_i=1 with g2_hatali_tahmin_i=1 -> next cycle gecerli=0; rst_i asserted with g2_guncelle_i -> all entries invalid afterward.
